// File: rtl/channel_frame_sequencer.sv
// ----------------------------------------------------------------------------
// channel_frame_sequencer
//
// Turns the latched channel configuration into a paced stream of read requests
// toward the SDRAM read port. Once started, it emits frames of frame_len words
// separated by blank_len idle cycles. The read address sweeps cyclically over
// the inclusive window [rdaddr_begin, rdaddr_end], and that window may wrap
// through zero.
//
// Ports
//   clk           clock
//   reset_n       asynchronous reset, active-low
//   frame_len     words per frame; 0 means "do not start"
//   blank_len     idle cycles between frames; 0 gives back-to-back frames
//   start         control level; a rising edge starts the channel
//   stop          control level; a rising edge requests a stop
//   rdaddr_begin  first read address of the window
//   rdaddr_end    last read address of the window (inclusive)
//   rd_ack        read port accepted rd_addr this cycle
//   rd_req        read request, held until rd_ack
//   rd_addr       address for rd_req (0 when no request is pending)
//   fifo_clr_out  single-cycle clear pulse to the channel FIFOs on start
//   frame_sof     pulses with the rd_ack of the first word of a frame
//   frame_eof     pulses with the rd_ack of the last word of a frame
//   busy          high whenever the sequencer is not idle
//   frame_cnt     completed frames since the last start (wraps)
// ----------------------------------------------------------------------------
module channel_frame_sequencer #(
  parameter int ADDR_W = 16,
  parameter int LEN_W  = 16,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [LEN_W-1:0]  frame_len,
  input  logic [LEN_W-1:0]  blank_len,
  input  logic              start,
  input  logic              stop,
  input  logic [ADDR_W-1:0] rdaddr_begin,
  input  logic [ADDR_W-1:0] rdaddr_end,
  input  logic              rd_ack,
  output logic              rd_req,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              fifo_clr_out,
  output logic              frame_sof,
  output logic              frame_eof,
  output logic              busy,
  output logic [CNT_W-1:0]  frame_cnt
);

  typedef enum logic [1:0] {IDLE, CLR, SEND, BLANK} state_t;

  state_t            state;
  state_t            next_state;

  logic              start_prev;
  logic              stop_prev;
  logic              armed;
  logic              start_edge;
  logic              stop_edge;

  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] addr_begin;
  logic [ADDR_W-1:0] addr_end;
  logic [LEN_W-1:0]  wcnt;
  logic [LEN_W-1:0]  len_l;
  logic [LEN_W-1:0]  bcnt;
  logic [LEN_W-1:0]  blen_l;
  logic              stop_pending;
  logic [CNT_W-1:0]  frame_cnt_r;

  logic              word_ack;
  logic              last_word;
  logic              blank_done;

  // armed stays low for the first cycle after reset. Because of that, a
  // control level that is already high when reset releases is taken as the
  // starting sample and not as a rising edge.
  assign start_edge = armed & start & ~start_prev;
  assign stop_edge  = armed & stop & ~stop_prev;

  // rd_ack counts only while a request is actually outstanding.
  assign word_ack   = (state == SEND) && rd_ack;
  assign last_word  = (wcnt == len_l - LEN_W'(1));
  assign blank_done = (bcnt == blen_l - LEN_W'(1));

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic. A stop request ends the channel only at a frame
  // boundary, with one exception: during a blank gap a stop takes effect at
  // once, because no frame is in flight.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: begin
        if (start_edge && (frame_len != '0) && !stop_edge) begin
          next_state = CLR;
        end
      end
      CLR: begin
        next_state = SEND;
      end
      SEND: begin
        if (word_ack && last_word) begin
          if (stop_pending || stop_edge) begin
            next_state = IDLE;
          end else if (blank_len == '0) begin
            next_state = SEND;
          end else begin
            next_state = BLANK;
          end
        end
      end
      BLANK: begin
        if (stop_edge) begin
          next_state = IDLE;
        end else if (blank_done) begin
          next_state = SEND;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Datapath: edge detection, the address window and the word, blank and
  // frame counters. The frame and blank lengths are re-latched on each entry
  // to SEND or BLANK, so a register change only affects the next frame or gap.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      start_prev   <= 1'b0;
      stop_prev    <= 1'b0;
      armed        <= 1'b0;
      addr         <= '0;
      addr_begin   <= '0;
      addr_end     <= '0;
      wcnt         <= '0;
      len_l        <= '0;
      bcnt         <= '0;
      blen_l       <= '0;
      stop_pending <= 1'b0;
      frame_cnt_r  <= '0;
    end else begin
      start_prev <= start;
      stop_prev  <= stop;
      armed      <= 1'b1;
      unique case (state)
        IDLE: begin
          stop_pending <= 1'b0;
        end
        CLR: begin
          addr_begin   <= rdaddr_begin;
          addr_end     <= rdaddr_end;
          addr         <= rdaddr_begin;
          frame_cnt_r  <= '0;
          stop_pending <= stop_edge;
          wcnt         <= '0;
          len_l        <= frame_len;
        end
        SEND: begin
          if (stop_edge) begin
            stop_pending <= 1'b1;
          end
          if (word_ack) begin
            addr <= (addr == addr_end) ? addr_begin : addr + ADDR_W'(1);
            if (last_word) begin
              frame_cnt_r <= frame_cnt_r + CNT_W'(1);
              wcnt        <= '0;
              len_l       <= frame_len;
              bcnt        <= '0;
              blen_l      <= blank_len;
            end else begin
              wcnt <= wcnt + LEN_W'(1);
            end
          end
        end
        BLANK: begin
          if (blank_done) begin
            wcnt  <= '0;
            len_l <= frame_len;
          end else begin
            bcnt <= bcnt + LEN_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Output decode. frame_sof and frame_eof follow rd_ack combinationally, so
  // each pulse lines up with the acceptance of its word.
  always_comb begin
    fifo_clr_out = 1'b0;
    rd_req       = 1'b0;
    rd_addr      = '0;
    frame_sof    = 1'b0;
    frame_eof    = 1'b0;
    busy         = (state != IDLE);
    frame_cnt    = frame_cnt_r;
    unique case (state)
      CLR: fifo_clr_out = 1'b1;
      SEND: begin
        rd_req    = 1'b1;
        rd_addr   = addr;
        frame_sof = rd_ack && (wcnt == '0);
        frame_eof = rd_ack && last_word;
      end
      default: ;
    endcase
  end

endmodule
